frame_serializer: RTL and testbench

Reads a complete complex frame (N real and N imaginary words, held in the parallel frame register) and streams it out one complex sample per cycle over a valid/ready interface. It sits downstream of the parallel frame register and upstream of any sample-serial consumer, such as an output FIFO or a DMA/UART bridge. On a start request it snapshots the frame, so the frame register may be rewritten immediately after the snapshot.

---
 rtl/fft_pkg.sv | 42 ++++
 rtl/frame_serializer.sv | 136 +++++++++++++
 tb/tb_frame_serializer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared frame defaults, sample types, serializer states and index bit reversal
//
// Contents:
//   N_DEF, W_DEF, LOG2N : default frame size, word width and index width
//   sample_t, cplx_t    : W-bit sample word and {r,i} complex sample
//   state_t             : serializer FSM states (IDLE, STREAM)
//   bitrev()            : reverses the low 'bits' bits of an index
package fft_pkg;

  localparam int N_DEF = 64;
  localparam int W_DEF = 32;
  localparam int LOG2N = $clog2(N_DEF);

  typedef logic [W_DEF-1:0] sample_t;

  typedef struct packed {
    sample_t r;
    sample_t i;
  } cplx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Shift-based reversal: the low 'bits' bits of idx come out mirrored,
  // all higher result bits stay zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int bits);
    logic [31:0] r;
    logic [31:0] x;
    r = '0;
    x = idx;
    for (int b = 0; b < 32; b++) begin
      if (b < bits) begin
        r = {r[30:0], x[0]};
        x = x >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_serializer.sv
// rtl/frame_serializer.sv - snapshots a parallel complex frame and streams it one sample per cycle
//
// Build option: define FRAME_SER_BITREV_EN to emit samples in bit-reversed
// index order (natural-order output from a bit-reversed frame); otherwise
// samples leave in natural index order. Handshake timing is the same.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      snapshot fr/fi and begin streaming (honoured only while idle)
//   fr, fi     N packed W-bit real / imaginary words, word j at [j*W +: W]
//   idle       high when a start would be accepted
//   out_r/i    current sample, registered
//   out_valid  sample valid
//   out_ready  consumer accepts the sample this cycle
//   out_last   current sample is the last of the frame
//   done       one-cycle pulse after the final beat is accepted
module frame_serializer
  import fft_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N*W-1:0] fr,
  input  logic [N*W-1:0] fi,
  output logic           idle,
  output logic [W-1:0]   out_r,
  output logic [W-1:0]   out_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           done
);

  localparam int LOGN = $clog2(N);
  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

  state_t          state_q, state_d;
  logic [LOGN-1:0] idx_q, idx_d;
  logic [W-1:0]    buf_r_q [N];
  logic [W-1:0]    buf_r_d [N];
  logic [W-1:0]    buf_i_q [N];
  logic [W-1:0]    buf_i_d [N];
  logic [W-1:0]    out_r_q, out_r_d;
  logic [W-1:0]    out_i_q, out_i_d;
  logic            out_last_q, out_last_d;
  logic            done_q, done_d;
  logic [LOGN-1:0] idx_nx;

  // Maps the beat index to the buffer slot it reads.
  function automatic logic [LOGN-1:0] ord(input logic [LOGN-1:0] i);
`ifdef FRAME_SER_BITREV_EN
    logic [31:0] t;
    t = bitrev(32'(i), LOGN);
    return t[LOGN-1:0];
`else
    return i;
`endif
  endfunction

  assign idx_nx = idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_r_d    = buf_r_q;
    buf_i_d    = buf_i_q;
    out_r_d    = out_r_q;
    out_i_d    = out_i_q;
    out_last_d = out_last_q;
    done_d     = 1'b0;

    if (state_q == IDLE) begin
      if (start) begin
        for (int j = 0; j < N; j++) begin
          buf_r_d[j] = fr[j*W +: W];
          buf_i_d[j] = fi[j*W +: W];
        end
        // ord(0) is 0 in both orders, so sample 0 comes straight from the inputs.
        out_r_d    = fr[W-1:0];
        out_i_d    = fi[W-1:0];
        out_last_d = 1'b0;
        idx_d      = '0;
        state_d    = STREAM;
      end
    end else begin
      if (out_ready) begin
        if (idx_q == LAST_IDX) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          out_last_d = 1'b0;
          idx_d      = '0;
        end else begin
          // Preload the next sample so the outputs stay purely registered.
          idx_d      = idx_nx;
          out_r_d    = buf_r_q[ord(idx_nx)];
          out_i_d    = buf_i_q[ord(idx_nx)];
          out_last_d = (idx_nx == LAST_IDX);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      buf_r_q    <= '{default: '0};
      buf_i_q    <= '{default: '0};
      out_r_q    <= '0;
      out_i_q    <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_r_q    <= buf_r_d;
      buf_i_q    <= buf_i_d;
      out_r_q    <= out_r_d;
      out_i_q    <= out_i_d;
      out_last_q <= out_last_d;
      done_q     <= done_d;
    end
  end

  assign idle      = (state_q == IDLE);
  assign out_valid = (state_q == STREAM);
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_frame_serializer.sv
// tb/tb_frame_serializer.sv - randomized self-checking bench for frame_serializer against a queue model
module tb_frame_serializer;
  import fft_pkg::*;

  localparam int N = N_DEF;
  localparam int W = W_DEF;

  logic           clk;
  logic           reset;
  logic           start;
  logic [N*W-1:0] fr;
  logic [N*W-1:0] fi;
  logic           idle;
  logic [W-1:0]   out_r;
  logic [W-1:0]   out_i;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic           done;

  logic [W-1:0] fr_a [N];
  logic [W-1:0] fi_a [N];

  int n_checks = 0;
  int n_err    = 0;

  // Model: queue of samples still owed to the consumer.
  cplx_t  exp_q[$];
  bit     m_busy     = 1'b0;
  bit     m_done     = 1'b0;
  bit     m_known    = 1'b0;
  bit     prev_stall = 1'b0;
  logic [W-1:0] prev_r;
  logic [W-1:0] prev_i;
  logic         prev_last;
  int     dut_beats  = 0;

  frame_serializer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .fr        (fr),
    .fi        (fi),
    .idle      (idle),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    fr = '0;
    fi = '0;
    for (int j = 0; j < N; j++) begin
      fr[j*W +: W] = fr_a[j];
      fi[j*W +: W] = fi_a[j];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output position k carries frame word ord(k); reversal done arithmetically.
  function automatic int tb_ord(input int k);
`ifdef FRAME_SER_BITREV_EN
    int r;
    int x;
    r = 0;
    x = k;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
`else
    return k;
`endif
  endfunction

  // Checks the current cycle, drives this cycle's inputs, advances the model
  // and the clock. Called just after an active edge.
  task automatic cycle(input logic rdy, input logic st, input logic rst);
    bit nd;
    cplx_t s;
    if (m_known) begin
      chk("idle", 64'(idle), 64'(!m_busy));
      chk("valid", 64'(out_valid), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      if (m_busy) begin
        chk("out_r", 64'(out_r), 64'(exp_q[0].r));
        chk("out_i", 64'(out_i), 64'(exp_q[0].i));
        chk("last", 64'(out_last), 64'(exp_q.size() == 1));
      end
      if (m_busy && prev_stall) begin
        chk("stall_r", 64'(out_r), 64'(prev_r));
        chk("stall_i", 64'(out_i), 64'(prev_i));
        chk("stall_last", 64'(out_last), 64'(prev_last));
      end
    end
    out_ready = rdy;
    start     = st;
    reset     = rst;
    if (out_valid === 1'b1 && rdy && !rst) dut_beats++;
    prev_stall = m_busy && !rdy && !rst;
    prev_r     = out_r;
    prev_i     = out_i;
    prev_last  = out_last;
    nd = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      exp_q.delete();
      m_known = 1'b1;
    end else if (m_busy) begin
      if (rdy) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_busy = 1'b0;
          nd = 1'b1;
        end
      end
    end else if (st) begin
      for (int k = 0; k < N; k++) begin
        s.r = fr_a[tb_ord(k)];
        s.i = fi_a[tb_ord(k)];
        exp_q.push_back(s);
      end
      m_busy = 1'b1;
    end
    m_done = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int j = 0; j < N; j++) begin
      fr_a[j] = $urandom;
      fi_a[j] = $urandom;
    end
  endtask

  task automatic run_out(input bit rnd);
    for (int t = 0; t < 2000 && (m_busy || m_done); t++)
      cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
    chk("run_out_end", 64'(out_valid), 64'd0);
  endtask

  int b0;

  initial begin
    for (int j = 0; j < N; j++) begin
      fr_a[j] = '0;
      fi_a[j] = '0;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;

    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("rst_out_r", 64'(out_r), 64'd0);
    chk("rst_out_i", 64'(out_i), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);

    // Ramp frame, ready held high: N beats then done in cycle N+1.
    for (int j = 0; j < N; j++) begin
      fr_a[j] = W'(j);
      fi_a[j] = W'(100 + j);
    end
    b0 = dut_beats;
    cycle(1'b1, 1'b1, 1'b0);
    repeat (N) cycle(1'b1, 1'b0, 1'b0);
    chk("done_at_n_plus_1", 64'(done), 64'd1);
    chk("idle_at_done", 64'(idle), 64'd1);
    chk("ramp_beats", 64'(dut_beats - b0), 64'(N));
    cycle(1'b1, 1'b0, 1'b0);
    chk("done_one_cycle", 64'(done), 64'd0);

    // Random backpressure.
    fill_random();
    b0 = dut_beats;
    cycle(1'b1, 1'b1, 1'b0);
    run_out(1'b1);
    chk("bp_beats", 64'(dut_beats - b0), 64'(N));

    // Frame register rewritten right after the snapshot.
    fill_random();
    cycle(1'b1, 1'b1, 1'b0);
    for (int j = 0; j < N; j++) begin
      fr_a[j] = 32'hDEADBEEF;
      fi_a[j] = 32'hDEADBEEF;
    end
    run_out(1'b1);

    // start held high mid-stream is ignored.
    fill_random();
    b0 = dut_beats;
    cycle(1'b1, 1'b1, 1'b0);
    repeat (40) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    run_out(1'b1);
    chk("ign_start_beats", 64'(dut_beats - b0), 64'(N));

    // Reset while beat 20 is on the outputs.
    fill_random();
    cycle(1'b1, 1'b1, 1'b0);
    repeat (20) cycle(1'b1, 1'b0, 1'b0);
    chk("pre_rst_r", 64'(out_r), 64'(fr_a[tb_ord(20)]));
    cycle(1'b1, 1'b0, 1'b1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_done", 64'(done), 64'd0);
    fill_random();
    cycle(1'b1, 1'b1, 1'b0);
    chk("restart_s0", 64'(out_r), 64'(fr_a[0]));
    run_out(1'b1);

    // Back-to-back: new start accepted in the done cycle.
    fill_random();
    cycle(1'b1, 1'b1, 1'b0);
    repeat (N) cycle(1'b1, 1'b0, 1'b0);
    chk("b2b_done", 64'(done), 64'd1);
    fill_random();
    cycle(1'b1, 1'b1, 1'b0);
    chk("b2b_valid", 64'(out_valid), 64'd1);
    run_out(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
